// File: rtl/fc_io_pkg.sv
// Shared types and width helpers for the FC layer stream front/back end.
package fc_io_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, EMIT} state_t;

  function automatic int fc_zw(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  function automatic longint sat_lim(input int width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational ZW->WIDTH requantizer: optional round-half-up (FC_IO_ROUND_EN), right shift, saturate to max positive.
module fc_requant
  import fc_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ZW    = 23,
  parameter int SHIFT = 4
) (
  input  logic [ZW-1:0]    z,
  output logic [WIDTH-1:0] q
);

  localparam logic [ZW:0] LIM = (ZW+1)'(sat_lim(WIDTH));
`ifdef FC_IO_ROUND_EN
  localparam logic [ZW:0] RND = (SHIFT > 0) ? ((ZW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
  localparam logic [ZW:0] RND = '0;
`endif

  logic [ZW:0] sum;
  logic [ZW:0] sh;

  // One extra bit keeps the rounding add from wrapping at full-scale z.
  always_comb begin
    sum = {1'b0, z} + RND;
    sh  = sum >> SHIFT;
    q   = (sh > LIM) ? LIM[WIDTH-1:0] : sh[WIDTH-1:0];
  end

endmodule

// File: rtl/fc_stream_io.sv
// Deserializes activations into the FC layer's parallel input, waits for the layer to settle, then
// requantizes and serializes the neuron sums. Define FC_IO_ROUND_EN for round-half-up requantization.
module fc_stream_io
  import fc_io_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IN         = 128,
  parameter int OUT        = 10,
  parameter int SETTLE_CYC = 2,
  parameter int SHIFT      = 4,
  localparam int ZW        = fc_zw(WIDTH, IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [ZW-1:0]    z [0:OUT-1],
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             frame_err,
  output logic             busy
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int CW = $clog2(SETTLE_CYC + 1);

  state_t         state;
  logic [IW-1:0]  wr_idx;
  logic [OW-1:0]  rd_idx;
  logic [CW-1:0]  cnt;
  logic [ZW-1:0]  zcap [0:OUT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_idx    <= '0;
      rd_idx    <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < IN; i++) x[i] <= '0;
      for (int j = 0; j < OUT; j++) zcap[j] <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          if (s_valid) begin
            x[wr_idx] <= s_data;
            if (wr_idx == IW'(IN - 1)) begin
              state <= SETTLE;
              if (!s_last) frame_err <= 1'b1;
            end else if (s_last) begin
              // Short frame: clear the tail so the layer never sees the previous frame's words.
              for (int i = 0; i < IN; i++)
                if (i > int'(wr_idx)) x[i] <= '0;
              frame_err <= 1'b1;
              state     <= SETTLE;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        SETTLE: begin
          // Capture edge is SETTLE_CYC+1 edges after the last write, giving the layer a full SETTLE_CYC-cycle path.
          if (cnt == CW'(SETTLE_CYC)) begin
            cnt <= '0;
            for (int j = 0; j < OUT; j++) zcap[j] <= z[j];
            state <= EMIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EMIT: begin
          if (m_ready) begin
            if (rd_idx == OW'(OUT - 1)) begin
              rd_idx <= '0;
              wr_idx <= '0;
              state  <= LOAD;
            end else begin
              rd_idx <= rd_idx + OW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready = (state == LOAD);
  assign m_valid = (state == EMIT);
  assign busy    = (state != LOAD);
  assign m_last  = (state == EMIT) && (rd_idx == OW'(OUT - 1));

  fc_requant #(
    .WIDTH(WIDTH),
    .ZW   (ZW),
    .SHIFT(SHIFT)
  ) u_requant (
    .z(zcap[rd_idx]),
    .q(m_data)
  );

endmodule

// File: tb/tb_fc_stream_io.sv
// Directed self-checking bench for fc_stream_io at default parameters.
module tb_fc_stream_io;
  import fc_io_pkg::*;

  localparam int ZW = fc_zw(8, 128);

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [7:0]    s_data;
  logic [7:0]    x [0:127];
  logic [ZW-1:0] z [0:9];
  logic          m_valid, m_ready, m_last, frame_err, busy;
  logic [7:0]    m_data;
  logic [7:0]    exp_q [0:9];

  int total = 0;
  int bad   = 0;

  fc_stream_io dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .x(x), .z(z),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic set_z_all(input logic [ZW-1:0] v);
    for (int j = 0; j < 10; j++) z[j] = v;
  endtask

  task automatic set_exp_all(input logic [7:0] v);
    for (int j = 0; j < 10; j++) exp_q[j] = v;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("s_ready_timeout", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input int step, input bit last_en);
    for (int k = 0; k < n; k++)
      send_word(8'(base + step * k), last_en && (k == n - 1));
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!m_valid && c < 20) begin
      @(posedge clk); #1; c++;
    end
    chk(tag, c, 3);
  endtask

  task automatic recv(input bit toggle);
    int got = 0;
    int guard = 0;
    bit r = 1'b1;
    while (got < 10 && guard < 100) begin
      m_ready = toggle ? r : 1'b1;
      if (m_valid) begin
        chk("m_data", m_data, exp_q[got]);
        chk("m_last", m_last, (got == 9));
        if (m_ready) got++;
      end
      @(posedge clk); #1;
      guard++;
      r = ~r;
    end
    m_ready = 1'b0;
    chk("out_count", got, 10);
    chk("s_ready_after_emit", s_ready, 1);
    chk("m_valid_after_emit", m_valid, 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    set_z_all(ZW'(24'h000123));
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 1);
    chk("rst_x0", x[0], 0);
    rst = 1'b0;

    // Frame A: x[i]=i, all neurons 0x123; input noise during SETTLE/EMIT must be ignored.
    send_frame(128, 0, 1, 1);
    chk("a_busy", busy, 1);
    chk("a_s_ready", s_ready, 0);
    chk("a_x0", x[0], 0);
    chk("a_x64", x[64], 64);
    chk("a_x127", x[127], 127);
    chk("a_frame_err", frame_err, 0);
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
    set_exp_all(8'h12);
    wait_valid("a_latency");
    recv(1'b0);
    s_valid = 1'b0; s_last = 1'b0;
    chk("a_x0_hold", x[0], 0);
    chk("a_x127_hold", x[127], 127);

    // Frame B: mixed requant corner cases, m_ready toggling.
    z = '{ZW'(296), ZW'(5000), ZW'(0), ZW'(291), ZW'(24'h123),
          ZW'(2047), ZW'(2048), ZW'(16), ZW'(15), ZW'(8)};
`ifdef FC_IO_ROUND_EN
    exp_q = '{8'h13, 8'h7F, 8'h00, 8'h12, 8'h12, 8'h7F, 8'h7F, 8'h01, 8'h01, 8'h01};
`else
    exp_q = '{8'h12, 8'h7F, 8'h00, 8'h12, 8'h12, 8'h7F, 8'h7F, 8'h01, 8'h00, 8'h00};
`endif
    send_frame(128, 255, -1, 1);
    chk("b_x0", x[0], 255);
    chk("b_x127", x[127], 128);
    wait_valid("b_latency");
    recv(1'b1);

    // Frame C: s_last on word 99 -> zero-filled tail, sticky error.
    set_z_all(ZW'(24'h000123));
    set_exp_all(8'h12);
    send_frame(100, 8'h55, 0, 1);
    chk("c_x99", x[99], 8'h55);
    chk("c_x100", x[100], 0);
    chk("c_x127", x[127], 0);
    chk("c_frame_err", frame_err, 1);
    wait_valid("c_latency");
    recv(1'b0);

    // Frame D: clean frame, error must stay set.
    set_z_all(ZW'(5000));
    set_exp_all(8'h7F);
    send_frame(128, 3, 2, 1);
    chk("d_x100", x[100], 203);
    chk("d_x127", x[127], 1);
    chk("d_frame_err", frame_err, 1);
    wait_valid("d_latency");
    recv(1'b0);

    // Reset during word 60 of a frame.
    send_frame(60, 9, 1, 0);
    s_valid = 1'b1; s_data = 8'd69;
    #2 rst = 1'b1;
    #1;
    chk("mr_s_ready", s_ready, 0);
    chk("mr_m_valid", m_valid, 0);
    chk("mr_m_data", m_data, 0);
    chk("mr_m_last", m_last, 0);
    chk("mr_busy", busy, 1);
    chk("mr_frame_err", frame_err, 0);
    chk("mr_x0", x[0], 0);
    chk("mr_x59", x[59], 0);
    s_valid = 1'b0;
    #10 rst = 1'b0;

    // Frame E after the aborted one.
    set_z_all(ZW'(24'h000123));
    set_exp_all(8'h12);
    send_frame(128, 1, 1, 1);
    chk("e_x0", x[0], 1);
    chk("e_x60", x[60], 61);
    chk("e_x127", x[127], 128);
    chk("e_frame_err", frame_err, 0);
    wait_valid("e_latency");
    recv(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
